// File: rtl/atp_pkg.sv
// Shared definitions for the change dispenser: FSM states, denomination codes
// and the code-to-value table used by both the selector and the datapath.
package atp_pkg;

    localparam int AMT_W   = 10;
    localparam int DEN_W   = 4;
    localparam int CNT_W   = 4;
    localparam int NUM_DEN = 9;

    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [DEN_W-1:0] DEN_500 = 4'd0;
    localparam logic [DEN_W-1:0] DEN_200 = 4'd1;
    localparam logic [DEN_W-1:0] DEN_100 = 4'd2;
    localparam logic [DEN_W-1:0] DEN_50  = 4'd3;
    localparam logic [DEN_W-1:0] DEN_20  = 4'd4;
    localparam logic [DEN_W-1:0] DEN_10  = 4'd5;
    localparam logic [DEN_W-1:0] DEN_5   = 4'd6;
    localparam logic [DEN_W-1:0] DEN_2   = 4'd7;
    localparam logic [DEN_W-1:0] DEN_1   = 4'd8;

    // Codes 9-15 are unused and map to zero so they can never be subtracted.
    function automatic logic [AMT_W-1:0] den_value(input logic [DEN_W-1:0] code);
        case (code)
            DEN_500: den_value = 10'd500;
            DEN_200: den_value = 10'd200;
            DEN_100: den_value = 10'd100;
            DEN_50:  den_value = 10'd50;
            DEN_20:  den_value = 10'd20;
            DEN_10:  den_value = 10'd10;
            DEN_5:   den_value = 10'd5;
            DEN_2:   den_value = 10'd2;
            DEN_1:   den_value = 10'd1;
            default: den_value = 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/den_select.sv
// Greedy denomination picker: largest note value that does not exceed the
// remaining amount. Outputs code 0 / value 0 when nothing fits (remaining 0).
module den_select
    import atp_pkg::*;
(
    input  logic [AMT_W-1:0] remaining,
    output logic [DEN_W-1:0] code,
    output logic [AMT_W-1:0] value
);

    logic [NUM_DEN-1:0] fits;

    generate
        for (genvar gi = 0; gi < NUM_DEN; gi++) begin : g_fit
            assign fits[gi] = (den_value(DEN_W'(gi)) <= remaining);
        end
    endgenerate

    // Scan from the smallest note upward so the lowest fitting code wins.
    always_comb begin
        code  = '0;
        value = '0;
        for (int i = NUM_DEN - 1; i >= 0; i--) begin
            if (fits[i]) begin
                code  = DEN_W'(i);
                value = den_value(DEN_W'(i));
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Dispenses a change amount as a sequence of greedy-chosen notes using a
// valid/ack handshake to the note mechanism, with registered outputs.
module change_dispenser
    import atp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] EXCSO,
    input  logic             disp_ack,
    output logic             disp_vld,
    output logic [DEN_W-1:0] disp_den,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] notes_cnt
);

    state_t             state_reg;
    logic [AMT_W-1:0]   remaining_reg;
    logic [AMT_W-1:0]   issue_value_reg;
    logic               disp_vld_reg;
    logic [DEN_W-1:0]   disp_den_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [CNT_W-1:0]   notes_cnt_reg;

    logic [DEN_W-1:0]   sel_code;
    logic [AMT_W-1:0]   sel_value;

    den_select u_den_select (
        .remaining (remaining_reg),
        .code      (sel_code),
        .value     (sel_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            remaining_reg   <= '0;
            issue_value_reg <= '0;
            disp_vld_reg    <= 1'b0;
            disp_den_reg    <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            notes_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        remaining_reg <= EXCSO;
                        notes_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining_reg == '0) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        disp_den_reg    <= sel_code;
                        issue_value_reg <= sel_value;
                        disp_vld_reg    <= 1'b1;
                        state_reg       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // issue_value_reg never exceeds remaining_reg, so no underflow.
                    if (disp_ack) begin
                        remaining_reg <= remaining_reg - issue_value_reg;
                        notes_cnt_reg <= (notes_cnt_reg == CNT_MAX) ? CNT_MAX
                                                                    : notes_cnt_reg + 1'b1;
                        disp_vld_reg  <= 1'b0;
                        state_reg     <= ST_SELECT;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign disp_vld  = disp_vld_reg;
    assign disp_den  = disp_den_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign notes_cnt = notes_cnt_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized
// amounts and ack timing against a division-based change-making model.
module tb_change_dispenser;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] EXCSO;
    logic       disp_ack;
    logic       disp_vld;
    logic [3:0] disp_den;
    logic       busy;
    logic       done;
    logic [3:0] notes_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    int vals [9] = '{500, 200, 100, 50, 20, 10, 5, 2, 1};

    int obs_codes[$];
    int exp_codes[$];
    int obs_done, obs_vld_ever, obs_unstable, obs_gap_bad, obs_timeout;
    int first_vld, first_done;

    change_dispenser dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .EXCSO     (EXCSO),
        .disp_ack  (disp_ack),
        .disp_vld  (disp_vld),
        .disp_den  (disp_den),
        .busy      (busy),
        .done      (done),
        .notes_cnt (notes_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Change-making by repeated division over the denomination list.
    function automatic void model(input int amt);
        int rem;
        int n;
        exp_codes.delete();
        rem = amt;
        for (int i = 0; i < 9; i++) begin
            n   = rem / vals[i];
            rem = rem % vals[i];
            for (int k = 0; k < n; k++) exp_codes.push_back(i);
        end
    endfunction

    function automatic int exp_cnt();
        return (exp_codes.size() > 15) ? 15 : exp_codes.size();
    endfunction

    function automatic bit codes_equal();
        if (obs_codes.size() != exp_codes.size()) return 1'b0;
        foreach (obs_codes[i]) if (obs_codes[i] != exp_codes[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string codes_str(input int q[$]);
        string s;
        s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    // Runs one operation and records observations. ack_delay: 0 = ack tied high,
    // n>0 = ack n cycles after disp_vld rises, <0 = random ack every cycle.
    task automatic dispense(input logic [9:0] amt, input int ack_delay,
                            input int extra_at, input logic [9:0] extra_amt);
        int cyc, wait_cnt, prev_den;
        bit prev_vld, xfer1, xfer2, finished;
        obs_codes.delete();
        obs_done = 0; obs_vld_ever = 0; obs_unstable = 0; obs_gap_bad = 0; obs_timeout = 0;
        first_vld = -1; first_done = -1;
        cyc = 0; wait_cnt = 0; prev_den = 0;
        prev_vld = 0; xfer1 = 0; xfer2 = 0; finished = 0;
        @(negedge clk);
        start    = 1'b1;
        EXCSO    = amt;
        disp_ack = (ack_delay == 0) ? 1'b1 : 1'b0;
        while (!finished && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_at);
            EXCSO = start ? extra_amt : 10'($urandom);
            if (xfer1 && disp_vld) obs_gap_bad++;
            if (xfer2 && !(disp_vld || done)) obs_gap_bad++;
            if (disp_vld) begin
                obs_vld_ever = 1;
                if (first_vld < 0) first_vld = cyc;
                if (prev_vld && !xfer1 && disp_den != prev_den) obs_unstable++;
                wait_cnt++;
            end
            if (ack_delay == 0)     disp_ack = 1'b1;
            else if (ack_delay < 0) disp_ack = 1'($urandom_range(0, 1));
            else                    disp_ack = disp_vld && (wait_cnt > ack_delay);
            xfer2 = xfer1;
            xfer1 = disp_vld && disp_ack;
            if (xfer1) begin
                obs_codes.push_back(int'(disp_den));
                wait_cnt = 0;
            end
            prev_vld = disp_vld;
            prev_den = disp_den;
            if (done) begin
                obs_done++;
                if (first_done < 0) first_done = cyc;
            end
            if (obs_done > 0 && !busy) finished = 1;
        end
        if (!finished) obs_timeout = 1;
        start    = 1'b0;
        disp_ack = 1'b0;
        $display("[TB] op amt=%0d ack=%0d notes_cnt=%0d done=%0d codes: %s",
                 amt, ack_delay, notes_cnt, obs_done, codes_str(obs_codes));
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; EXCSO = '0; disp_ack = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({disp_vld, disp_den, busy, done, notes_cnt} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got vld=%b den=%0d busy=%b done=%b cnt=%0d, want all 0",
                     disp_vld, disp_den, busy, done, notes_cnt);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({disp_vld, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_hold: got vld=%b busy=%b done=%b, want 0 0 0", disp_vld, busy, done);
        end
    endtask

    task automatic test_zero();
        dispense(10'd0, 0, -1, '0);
        tests_run++;
        if (first_done != 2 || obs_vld_ever != 0 || notes_cnt !== 4'd0 || obs_done != 1 || obs_timeout) begin
            tests_failed++;
            $display("FAIL zero_amount: got done_at=%0d vld_ever=%0d cnt=%0d dones=%0d to=%0d, want 2 0 0 1 0",
                     first_done, obs_vld_ever, notes_cnt, obs_done, obs_timeout);
        end
    endtask

    task automatic test_single();
        dispense(10'd50, 0, -1, '0);
        model(50);
        tests_run++;
        if (!codes_equal() || notes_cnt !== 4'd1 || obs_done != 1 || first_vld != 2) begin
            tests_failed++;
            $display("FAIL single_50: got codes=%s cnt=%0d dones=%0d vld_at=%0d, want codes=%s cnt=1 dones=1 vld_at=2",
                     codes_str(obs_codes), notes_cnt, obs_done, first_vld, codes_str(exp_codes));
        end
    endtask

    task automatic test_all_dens();
        dispense(10'd888, 0, -1, '0);
        model(888);
        tests_run++;
        if (!codes_equal() || notes_cnt !== 4'd9 || obs_done != 1 || obs_gap_bad != 0) begin
            tests_failed++;
            $display("FAIL all_888: got codes=%s cnt=%0d dones=%0d gaps=%0d, want codes=%s cnt=9 dones=1 gaps=0",
                     codes_str(obs_codes), notes_cnt, obs_done, obs_gap_bad, codes_str(exp_codes));
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (notes_cnt !== 4'd9 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL cnt_hold: got cnt=%0d busy=%b, want 9 0", notes_cnt, busy);
        end
    endtask

    task automatic test_slow_ack();
        dispense(10'd7, 3, -1, '0);
        model(7);
        tests_run++;
        if (!codes_equal() || notes_cnt !== 4'd2 || obs_unstable != 0 || obs_gap_bad != 0) begin
            tests_failed++;
            $display("FAIL slow_ack_7: got codes=%s cnt=%0d unstable=%0d gaps=%0d, want codes=%s cnt=2 0 0",
                     codes_str(obs_codes), notes_cnt, obs_unstable, obs_gap_bad, codes_str(exp_codes));
        end
    endtask

    task automatic test_busy_start();
        dispense(10'd500, 3, 1, 10'd100);
        model(500);
        tests_run++;
        if (!codes_equal() || notes_cnt !== 4'd1 || obs_done != 1) begin
            tests_failed++;
            $display("FAIL busy_start: got codes=%s cnt=%0d dones=%0d, want codes=%s cnt=1 dones=1",
                     codes_str(obs_codes), notes_cnt, obs_done, codes_str(exp_codes));
        end
    endtask

    task automatic test_async_reset();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        start = 1'b1; EXCSO = 10'd888; disp_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (disp_vld !== 1'b1 || disp_den !== 4'd0) begin
            tests_failed++;
            $display("FAIL issue_before_rst: got vld=%b den=%0d, want 1 0", disp_vld, disp_den);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({disp_vld, disp_den, busy, done, notes_cnt} !== 11'd0) begin
            tests_failed++;
            $display("FAIL async_rst: got vld=%b den=%0d busy=%b done=%b cnt=%0d, want all 0",
                     disp_vld, disp_den, busy, done, notes_cnt);
        end
        repeat (2) @(negedge clk) if (done) seen_done++;
        rst = 1'b1;
        repeat (3) @(negedge clk) if (done) seen_done++;
        tests_run++;
        if (seen_done != 0) begin
            tests_failed++;
            $display("FAIL rst_no_done: got %0d done pulses, want 0", seen_done);
        end
        dispense(10'd20, 0, -1, '0);
        model(20);
        tests_run++;
        if (!codes_equal() || notes_cnt !== 4'd1 || obs_done != 1) begin
            tests_failed++;
            $display("FAIL after_rst_20: got codes=%s cnt=%0d dones=%0d, want codes=%s cnt=1 dones=1",
                     codes_str(obs_codes), notes_cnt, obs_done, codes_str(exp_codes));
        end
    endtask

    task automatic test_random();
        int amt;
        for (int t = 0; t < 20; t++) begin
            amt = (t == 0) ? 1023 : int'($urandom_range(0, 1023));
            dispense(10'(amt), -1, int'($urandom_range(1, 6)), 10'($urandom));
            model(amt);
            tests_run++;
            if (!codes_equal() || notes_cnt !== 4'(exp_cnt()) || obs_done != 1 ||
                obs_unstable != 0 || obs_gap_bad != 0 || obs_timeout != 0) begin
                tests_failed++;
                $display("FAIL random_%0d amt=%0d: got codes=%s cnt=%0d dones=%0d unstable=%0d gaps=%0d to=%0d, want codes=%s cnt=%0d",
                         t, amt, codes_str(obs_codes), notes_cnt, obs_done, obs_unstable,
                         obs_gap_bad, obs_timeout, codes_str(exp_codes), exp_cnt());
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single();
        test_all_dens();
        test_slow_ack();
        test_busy_start();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have: start  in  1  one-cycle pulse; EXCSO valid this cycle.
REQ-004 SHALL have: EXCSO  in  10  excess/change amount from the ATP controller, unsigned, units of 1.
REQ-005 SHALL have: disp_ack  in  1  note mechanism accepts current note.
REQ-006 SHALL have: disp_vld  out  1  a note request is pending.
REQ-007 SHALL have: disp_den  out  4  denomination code of the pending note.
REQ-008 SHALL have: busy  out  1  a dispense operation is in progress.
REQ-009 SHALL have: done  out  1  one-cycle pulse; operation complete.
REQ-010 SHALL have: notes_cnt  out  4  notes issued in the current or last operation.

Function
REQ-011 Denomination codes SHALL be: 0=500, 1=200, 2=100, 3=50, 4=20, 5=10, 6=5, 7=2, 8=1; codes 9-15 unused.
REQ-012 FSM states SHALL be IDLE, SELECT, ISSUE, DONE.
REQ-013 IDLE: on start=1, latch EXCSO into a 10-bit remaining register, clear notes_cnt, go to SELECT.
REQ-014 IDLE: start=0 SHALL hold IDLE with all outputs unchanged.
REQ-015 SELECT: remaining==0 -> DONE; else latch greedy code (largest value <= remaining) into disp_den, go to ISSUE.
REQ-016 ISSUE: disp_vld=1; disp_den SHALL stay stable until the transfer.
REQ-017 Transfer SHALL occur on a rising edge with disp_vld=1 and disp_ack=1: remaining -= value(disp_den), notes_cnt += 1, go to SELECT.
REQ-018 disp_ack while not in ISSUE SHALL be ignored.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE; notes_cnt SHALL hold until the next accepted start.
REQ-020 busy SHALL be 1 in SELECT, ISSUE and DONE, and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored; EXCSO is not re-latched.
REQ-022 Latency: start in cycle N -> disp_vld=1 in cycle N+2 (remaining>0).
REQ-023 Latency: start in cycle N -> done=1 in cycle N+2 (remaining==0).
REQ-024 Each ISSUE->SELECT->ISSUE cycle SHALL drop disp_vld for exactly one cycle (SELECT).
REQ-025 Subtraction SHALL never underflow; greedy choice guarantees value <= remaining.
REQ-026 notes_cnt SHALL saturate at 15.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, remaining=0, disp_vld=0, disp_den=0, busy=0, done=0, notes_cnt=0.
REQ-028 Reset mid-operation SHALL abandon the operation with no done pulse; the next start behaves as from power-up.

Structure
REQ-029 Shared package atp_pkg SHALL hold the FSM state encoding, denomination code constants, and denomination value table.
REQ-030 Greedy selection SHALL be a combinational sub-module den_select (remaining in; code and value out).

Verification
REQ-031 start, EXCSO=0 -> done=1 at N+2, disp_vld never 1, notes_cnt=0.
REQ-032 start, EXCSO=50, disp_ack tied 1 -> one note, disp_den=3, done pulse, notes_cnt=1.
REQ-033 start, EXCSO=888, disp_ack tied 1 -> codes 0,1,2,3,4,5,6,7,8 in order, notes_cnt=9, done once.
REQ-034 start, EXCSO=7, disp_ack raised 3 cycles after each disp_vld -> disp_vld and disp_den=6 held stable, then disp_den=7, notes_cnt=2.
REQ-035 EXCSO=500, second start with EXCSO=100 while busy -> exactly one note (code 0), second start ignored.
REQ-036 rst=0 asynchronously during ISSUE of EXCSO=888 -> all outputs 0 immediately, no done; subsequent start EXCSO=20 -> one note, code 4.
